// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the bus arbiter family
package bus_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

  localparam int GRANT_CNT_W = 16;

  // Counter must reach MAX_BURST itself, hence the +1.
  function automatic int beat_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick, searching upward from last_idx+1 with wrap
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] pick,
  output logic               pick_valid
);

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_valid && req[(int'(last_idx) + k) % NUM_REQ]) begin
        pick[(int'(last_idx) + k) % NUM_REQ] = 1'b1;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin burst arbiter muxing NUM_REQ requesters onto one valid/ready channel
// Optional per-requester grant counters: BUS_ARBITER_STATS_EN
module bus_arbiter import bus_arb_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         bus_data,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
`ifdef BUS_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*GRANT_CNT_W-1:0] grant_count
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W  = beat_cnt_w(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]   owner_idx;
  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic               own, owner_valid, beat;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req        (req_valid),
    .last_idx   (last_idx_q),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // grant_q is zero outside OWN, so the mux naturally yields zero data when idle.
  always_comb begin
    owner_idx = '0;
    bus_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = IDX_W'(i);
        bus_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign own         = (state_q == ARB_OWN);
  assign owner_valid = |(req_valid & grant_q);
  assign bus_valid   = own && owner_valid;
  assign req_ready   = own ? (grant_q & {NUM_REQ{bus_ready}}) : '0;
  assign beat        = bus_valid && bus_ready;
  assign grant       = grant_q;
  assign busy        = own;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_OWN;
          grant_d    = pick;
          beat_cnt_d = '0;
        end
      end
      ARB_OWN: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BC_W'(1);
        end
        // Release on the last beat of a burst, or when the owner has nothing to send.
        if ((beat && (beat_cnt_q == BC_W'(MAX_BURST - 1))) || !owner_valid) begin
          state_d    = ARB_IDLE;
          grant_d    = '0;
          last_idx_d = owner_idx;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      last_idx_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef BUS_ARBITER_STATS_EN
  logic [NUM_REQ*GRANT_CNT_W-1:0] grant_count_q, grant_count_d;

  always_comb begin
    grant_count_d = grant_count_q;
    if ((state_q == ARB_IDLE) && pick_valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick[i] && (grant_count_q[i*GRANT_CNT_W +: GRANT_CNT_W] != '1)) begin
          grant_count_d[i*GRANT_CNT_W +: GRANT_CNT_W] =
            grant_count_q[i*GRANT_CNT_W +: GRANT_CNT_W] + GRANT_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_count_q <= '0;
    end else begin
      grant_count_q <= grant_count_d;
    end
  end

  assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] req_data;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [31:0]  bus_data;
  logic         bus_valid;
  logic         bus_ready;
  logic [3:0]   grant;
  logic         busy;
`ifdef BUS_ARBITER_STATS_EN
  logic [63:0]  grant_count;
`endif

  bus_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .grant     (grant),
    .busy      (busy)
`ifdef BUS_ARBITER_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          k[4];
  int          lim[4];
  int          start[4];
  logic [31:0] base[4];
  int          cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      k[i] = 0; lim[i] = 0; start[i] = 0; base[i] = 32'h0;
    end
    cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'b0;
    req_data  = '0;
    bus_ready = 1'b1;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock of the requester model followed by output checks.
  task automatic cycle(input logic rdy, input logic [3:0] eg, input logic ev, input logic [31:0] ed);
    @(negedge clk);
    bus_ready = rdy;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (cyc >= start[i]) && (k[i] < lim[i]);
      req_data[i*32 +: 32] = base[i] + 32'(k[i]);
    end
    #1;
    check("grant", 64'(grant), 64'(eg));
    check("bus_valid", 64'(bus_valid), 64'(ev));
    check("bus_data", 64'(bus_data), 64'(ed));
    check("req_ready", 64'(req_ready), 64'(eg & {4{rdy}}));
    check("busy", 64'(busy), 64'(|eg));
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) k[i]++;
    end
    cyc++;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0;
    req_data  = '0;
    bus_ready = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_bus_valid", 64'(bus_valid), 64'h0);
    check("rst_bus_data", 64'(bus_data), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h0);

    // Single requester: two bursts split by one idle cycle, then early release.
    do_reset();
    base[2] = 32'hA0; lim[2] = 6;
    cycle(1, 4'b0000, 0, 32'h0);
    cycle(1, 4'b0100, 1, 32'hA0);
    cycle(1, 4'b0100, 1, 32'hA1);
    cycle(1, 4'b0100, 1, 32'hA2);
    cycle(1, 4'b0100, 1, 32'hA3);
    cycle(1, 4'b0000, 0, 32'h0);
    cycle(1, 4'b0100, 1, 32'hA4);
    cycle(1, 4'b0100, 1, 32'hA5);
    cycle(1, 4'b0100, 0, 32'hA6);
    cycle(1, 4'b0000, 0, 32'h0);

    // Round-robin fairness with all requesters valid.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      base[i] = 32'h100 * (i + 1); lim[i] = 100;
    end
    for (int r = 0; r < 5; r++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (r % 4);
      cycle(1, 4'b0000, 0, 32'h0);
`ifdef BUS_ARBITER_STATS_EN
      if (r == 4) check("grant_count", grant_count, {16'd1, 16'd1, 16'd1, 16'd1});
`endif
      for (int b = 0; b < 4; b++) begin
        cycle(1, oh, 1, 32'h100 * ((r % 4) + 1) + 32'(4 * (r / 4) + b));
      end
    end

    // Backpressure: ready low for five cycles after the first beat.
    do_reset();
    base[1] = 32'hC0; lim[1] = 4;
    cycle(1, 4'b0000, 0, 32'h0);
    cycle(1, 4'b0010, 1, 32'hC0);
    for (int j = 0; j < 5; j++) cycle(0, 4'b0010, 1, 32'hC1);
    cycle(1, 4'b0010, 1, 32'hC1);
    cycle(1, 4'b0010, 1, 32'hC2);
    cycle(1, 4'b0010, 1, 32'hC3);
    cycle(1, 4'b0000, 0, 32'h0);

    // Early release: req 1 arriving in the release cycle beats waiting req 3.
    do_reset();
    base[0] = 32'hD0; lim[0] = 2;
    base[3] = 32'hE0; lim[3] = 4;
    base[1] = 32'hF0; lim[1] = 2; start[1] = 3;
    cycle(1, 4'b0000, 0, 32'h0);
    cycle(1, 4'b0001, 1, 32'hD0);
    cycle(1, 4'b0001, 1, 32'hD1);
    cycle(1, 4'b0001, 0, 32'hD2);
    cycle(1, 4'b0000, 0, 32'h0);
    cycle(1, 4'b0010, 1, 32'hF0);
    cycle(1, 4'b0010, 1, 32'hF1);
    cycle(1, 4'b0010, 0, 32'hF2);
    cycle(1, 4'b0000, 0, 32'h0);
    cycle(1, 4'b1000, 1, 32'hE0);
    cycle(1, 4'b1000, 1, 32'hE1);
    cycle(1, 4'b1000, 1, 32'hE2);
    cycle(1, 4'b1000, 1, 32'hE3);
    cycle(1, 4'b0000, 0, 32'h0);

    // Reset mid-burst, asserted between edges.
    do_reset();
    base[0] = 32'h50; lim[0] = 10;
    base[2] = 32'h70; lim[2] = 10;
    cycle(1, 4'b0000, 0, 32'h0);
    cycle(1, 4'b0001, 1, 32'h50);
    cycle(1, 4'b0001, 1, 32'h51);
    #1 reset = 1'b1;
    #1;
    check("amid_grant", 64'(grant), 64'h0);
    check("amid_busy", 64'(busy), 64'h0);
    check("amid_bus_valid", 64'(bus_valid), 64'h0);
    check("amid_bus_data", 64'(bus_data), 64'h0);
    check("amid_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    k[0] = 0; k[2] = 0;
    cycle(1, 4'b0001, 1, 32'h50);
    cycle(1, 4'b0001, 1, 32'h51);
    cycle(1, 4'b0001, 1, 32'h52);
    cycle(1, 4'b0001, 1, 32'h53);
    cycle(1, 4'b0000, 0, 32'h0);
    cycle(1, 4'b0100, 1, 32'h70);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
